// File: rtl/dpe_wg_disasm_if.sv
// AXI-Stream style bus bundle shared by the disassembler input and output sides.
interface dpe_wg_disasm_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned USER_WIDTH = 5
) ();
  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tvalid, tlast, tdata, tkeep, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tlast, tdata, tkeep, tuser,
    output tready
  );
endinterface

// File: rtl/dpe_wg_disasm.sv
// WireGuard ingress disassembler: validates Eth/IPv4/UDP headers, drops non-WireGuard
// frames, strips the 42-byte L2-L4 header and realigns the UDP payload to lane 0.
module dpe_wg_disasm #(
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned INP_USER_WIDTH  = 5,
  parameter int unsigned OUTP_USER_WIDTH = 128,
  parameter logic [15:0] WG_PORT         = 16'd51820
) (
  input  logic            clk,
  input  logic            rst,
  dpe_wg_disasm_if.slave  inp,
  dpe_wg_disasm_if.master outp,
  output logic            fcr_idle
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_W      = $clog2(KEEP_WIDTH + 1);
  localparam int unsigned RES_BYTES  = 6;
  localparam int unsigned RES_W      = RES_BYTES * 8;
  localparam int unsigned NEW_W      = DATA_WIDTH - RES_W;
  localparam int unsigned PAD_W      = 8 - INP_USER_WIDTH;
  localparam int unsigned HDR_TAIL   = KEEP_WIDTH - RES_BYTES;

  typedef enum logic [2:0] {HDR0, HDR1, HDR2, PASS, FLUSH, DROP} state_t;

  state_t                       state_q;
  logic [INP_USER_WIDTH-1:0]    src_if_q;
  logic [31:0]                  src_ip_q;
  logic [15:0]                  dst_hi_q;
  logic [OUTP_USER_WIDTH-1:0]   meta_q;
  logic [RES_W-1:0]             resid_q;
  logic [KEEP_WIDTH-1:0]        flush_keep_q;

  logic                         out_valid_q;
  logic                         out_last_q;
  logic [DATA_WIDTH-1:0]        out_data_q;
  logic [KEEP_WIDTH-1:0]        out_keep_q;
  logic [OUTP_USER_WIDTH-1:0]   out_user_q;

  logic [7:0]                   lane_c [KEEP_WIDTH];
  logic [CNT_W-1:0]             beat_bytes_c;
  logic                         hdr0_ok_c;
  logic                         hdr1_ok_c;
  logic                         hdr2_ok_c;
  logic                         out_free_c;
  logic                         inp_ready_c;
  logic                         in_hs_c;
  logic [OUTP_USER_WIDTH-1:0]   meta_hdr2_c;

  // Contiguous byte-enable mask with the low n lanes set.
  function automatic logic [KEEP_WIDTH-1:0] keep_ones(input logic [CNT_W-1:0] n);
    logic [KEEP_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Byte lanes, valid-byte count and per-word header checks for the current beat.
  always_comb begin
    beat_bytes_c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      lane_c[i]    = inp.tdata[8*i +: 8];
      beat_bytes_c = beat_bytes_c + CNT_W'(inp.tkeep[i]);
    end
    hdr0_ok_c = (lane_c[12] == 8'h08) && (lane_c[13] == 8'h00) && (lane_c[14] == 8'h45);
    hdr1_ok_c = (lane_c[7] == 8'h11);
    hdr2_ok_c = ({lane_c[4], lane_c[5]} == WG_PORT) &&
                (lane_c[10] >= 8'd1) && (lane_c[10] <= 8'd4) &&
                (beat_bytes_c > CNT_W'(HDR_TAIL));
    meta_hdr2_c = OUTP_USER_WIDTH'({16'h0000, lane_c[10], PAD_W'(0), src_if_q,
                                    lane_c[4], lane_c[5], lane_c[2], lane_c[3],
                                    dst_hi_q, lane_c[0], lane_c[1], src_ip_q});
  end

  // Input backpressure: header and drop states always accept, except a final HDR2 beat
  // that needs the output register; PASS waits for the output register; FLUSH never accepts.
  always_comb begin
    out_free_c  = !out_valid_q || outp.tready;
    inp_ready_c = 1'b0;
    unique case (state_q)
      HDR0, HDR1, DROP: inp_ready_c = 1'b1;
      HDR2:             inp_ready_c = !inp.tlast || out_free_c;
      PASS:             inp_ready_c = out_free_c;
      default:          inp_ready_c = 1'b0;
    endcase
    in_hs_c = inp.tvalid && inp_ready_c;
  end

  assign inp.tready  = inp_ready_c;
  assign outp.tvalid = out_valid_q;
  assign outp.tlast  = out_last_q;
  assign outp.tdata  = out_data_q;
  assign outp.tkeep  = out_keep_q;
  assign outp.tuser  = out_user_q;
  assign fcr_idle    = (state_q == HDR0) && !out_valid_q;

  // Header parse, payload realignment and the single-stage output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HDR0;
      src_if_q     <= '0;
      src_ip_q     <= '0;
      dst_hi_q     <= '0;
      meta_q       <= '0;
      resid_q      <= '0;
      flush_keep_q <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_user_q   <= '0;
    end else begin
      if (outp.tready) out_valid_q <= 1'b0;

      unique case (state_q)
        HDR0: begin
          if (in_hs_c) begin
            src_if_q <= inp.tuser;
            if (inp.tlast)       state_q <= HDR0;
            else if (!hdr0_ok_c) state_q <= DROP;
            else                 state_q <= HDR1;
          end
        end

        HDR1: begin
          if (in_hs_c) begin
            src_ip_q <= {lane_c[10], lane_c[11], lane_c[12], lane_c[13]};
            dst_hi_q <= {lane_c[14], lane_c[15]};
            if (inp.tlast)       state_q <= HDR0;
            else if (!hdr1_ok_c) state_q <= DROP;
            else                 state_q <= HDR2;
          end
        end

        HDR2: begin
          if (in_hs_c) begin
            meta_q  <= meta_hdr2_c;
            resid_q <= inp.tdata[DATA_WIDTH-1 -: RES_W];
            if (!hdr2_ok_c) begin
              state_q <= inp.tlast ? HDR0 : DROP;
            end else if (inp.tlast) begin
              // Whole message sits in this beat: send the residual directly.
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b1;
              out_data_q  <= DATA_WIDTH'(inp.tdata[DATA_WIDTH-1 -: RES_W]);
              out_keep_q  <= keep_ones(beat_bytes_c - CNT_W'(HDR_TAIL));
              out_user_q  <= meta_hdr2_c;
              state_q     <= HDR0;
            end else begin
              state_q <= PASS;
            end
          end
        end

        PASS: begin
          if (in_hs_c) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {inp.tdata[NEW_W-1:0], resid_q};
            out_user_q  <= meta_q;
            resid_q     <= inp.tdata[DATA_WIDTH-1 -: RES_W];
            if (!inp.tlast) begin
              out_last_q <= 1'b0;
              out_keep_q <= '1;
            end else if (beat_bytes_c <= CNT_W'(HDR_TAIL)) begin
              out_last_q <= 1'b1;
              out_keep_q <= keep_ones(CNT_W'(RES_BYTES) + beat_bytes_c);
              state_q    <= HDR0;
            end else begin
              // Tail spills past this word; one more word carries the leftover bytes.
              out_last_q   <= 1'b0;
              out_keep_q   <= '1;
              flush_keep_q <= keep_ones(beat_bytes_c - CNT_W'(HDR_TAIL));
              state_q      <= FLUSH;
            end
          end
        end

        FLUSH: begin
          if (out_free_c) begin
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b1;
            out_data_q  <= DATA_WIDTH'(resid_q);
            out_keep_q  <= flush_keep_q;
            out_user_q  <= meta_q;
            state_q     <= HDR0;
          end
        end

        DROP: begin
          if (in_hs_c && inp.tlast) state_q <= HDR0;
        end

        default: state_q <= HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_dpe_wg_disasm.sv
// Bench for dpe_wg_disasm: table of frames driven back-to-back against a byte-level
// scoreboard, plus output-stall, idle-flag and mid-frame reset sequences.
module tb_dpe_wg_disasm;

  localparam logic [15:0] WG_PORT = 16'd51820;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [127:0] user;
  } exp_t;

  typedef struct {
    logic [15:0] ethertype;
    logic [7:0]  ver;
    logic [7:0]  proto;
    logic [15:0] dport;
    logic [7:0]  wtype;
    logic [4:0]  src_if;
    int          nwords;
    logic [15:0] last_keep;
    int          exp_words;
    int          exp_stalls;
  } row_t;

  logic clk;
  logic rst;
  logic fcr_idle;

  dpe_wg_disasm_if #(.DATA_WIDTH(128), .USER_WIDTH(5))   inp_if ();
  dpe_wg_disasm_if #(.DATA_WIDTH(128), .USER_WIDTH(128)) outp_if ();

  dpe_wg_disasm #(
    .DATA_WIDTH(128), .INP_USER_WIDTH(5), .OUTP_USER_WIDTH(128), .WG_PORT(WG_PORT)
  ) dut (
    .clk(clk), .rst(rst), .inp(inp_if), .outp(outp_if), .fcr_idle(fcr_idle)
  );

  int checks;
  int errors;
  int out_words;
  exp_t sbq[$];
  logic [7:0] fb [0:255];
  int flen;
  logic frame_pass;
  logic acc;
  logic bp_mode;
  logic [5:0] bp_pat;
  int bp_cyc;
  logic hold_pend;
  exp_t held;
  exp_t got;
  exp_t want;
  logic [127:0] dmask;
  row_t rows [13];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Input handshake as seen at the clock edge.
  always @(posedge clk) acc <= inp_if.tvalid && inp_if.tready;

  // Output-ready pattern with 1- and 2-cycle low gaps.
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      outp_if.tready = bp_pat[bp_cyc % 6];
      bp_cyc++;
    end
  end

  // Output monitor: hold-stability while stalled, scoreboard compare on handshake.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else if (outp_if.tvalid) begin
      got.data = outp_if.tdata;
      got.keep = outp_if.tkeep;
      got.last = outp_if.tlast;
      got.user = outp_if.tuser;
      if (hold_pend) begin
        check("hold_data", got.data, held.data);
        check("hold_keep", 128'(got.keep), 128'(held.keep));
        check("hold_user", got.user, held.user);
      end
      if (outp_if.tready) begin
        hold_pend = 1'b0;
        out_words++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data %0h keep %0h, required no output", got.data, got.keep);
        end else begin
          want = sbq.pop_front();
          dmask = '0;
          for (int i = 0; i < 16; i++) dmask[8*i +: 8] = {8{want.keep[i]}};
          check("out_data", got.data & dmask, want.data);
          check("out_keep", 128'(got.keep), 128'(want.keep));
          check("out_last", 128'(got.last), 128'(want.last));
          check("out_user", got.user, want.user);
        end
      end else begin
        held = got;
        hold_pend = 1'b1;
      end
    end
  end

  // Build a frame into fb[] and decide whether it is a valid WireGuard frame.
  task automatic build_frame(input logic [15:0] et, input logic [7:0] ver, input logic [7:0] proto,
                             input logic [15:0] dport, input logic [7:0] wtype, input int nwords,
                             input logic [15:0] last_keep, input int seed);
    flen = (nwords - 1) * 16 + $countones(last_keep);
    for (int i = 0; i < 16 * nwords; i++) fb[i] = (i < flen) ? 8'(i * 13 + seed) : 8'hEE;
    for (int i = 0; i < 6; i++) fb[i] = 8'hFF;
    fb[6] = 8'h02; fb[7] = 8'h00; fb[8] = 8'h00; fb[9] = 8'h00; fb[10] = 8'h00; fb[11] = 8'h01;
    fb[12] = et[15:8]; fb[13] = et[7:0];
    fb[14] = ver; fb[15] = 8'h00;
    fb[16] = 8'((flen - 14) >> 8); fb[17] = 8'(flen - 14);
    for (int i = 18; i < 22; i++) fb[i] = 8'h00;
    fb[22] = 8'd64; fb[23] = proto; fb[24] = 8'h00; fb[25] = 8'h00;
    fb[26] = 8'd10; fb[27] = 8'd9; fb[28] = 8'd0; fb[29] = 8'd1;
    fb[30] = 8'd10; fb[31] = 8'd9;
    if (nwords > 2) begin
      fb[32] = 8'd0; fb[33] = 8'd2;
      fb[34] = 8'hA9; fb[35] = 8'hC6;
      fb[36] = dport[15:8]; fb[37] = dport[7:0];
      fb[38] = 8'((flen - 34) >> 8); fb[39] = 8'(flen - 34);
      fb[40] = 8'h00; fb[41] = 8'h00;
      fb[42] = wtype; fb[43] = 8'h00; fb[44] = 8'h00; fb[45] = 8'h00;
    end
    frame_pass = (et == 16'h0800) && (ver == 8'h45) && (proto == 8'h11) && (dport == WG_PORT) &&
                 (wtype >= 8'd1) && (wtype <= 8'd4) && (flen >= 43);
  endtask

  // Queue the expected payload words (bytes 42..flen-1) of the frame in fb[].
  task automatic model_push(input logic [7:0] wtype, input logic [4:0] src_if, input logic [15:0] dport);
    exp_t e;
    int nbytes;
    int idx;
    if (!frame_pass) return;
    nbytes = flen - 42;
    for (int k = 0; k * 16 < nbytes; k++) begin
      e.data = '0;
      e.keep = '0;
      for (int i = 0; i < 16; i++) begin
        idx = 42 + 16 * k + i;
        if (idx < flen) begin
          e.data[8*i +: 8] = fb[idx];
          e.keep[i] = 1'b1;
        end
      end
      e.last = ((k + 1) * 16 >= nbytes);
      e.user = {16'h0000, wtype, 3'b000, src_if, dport, 16'hA9C6, 32'h0A090002, 32'h0A090001};
      sbq.push_back(e);
    end
  endtask

  // Drive up to max_beats beats of the frame in fb[]; report cycles spent waiting on tready.
  task automatic send_frame(input int nwords, input logic [15:0] last_keep, input logic [4:0] tuser,
                            input int max_beats, output int stalls);
    logic [127:0] d;
    int waited;
    stalls = 0;
    for (int w = 0; w < nwords && w < max_beats; w++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = fb[16 * w + i];
      inp_if.tdata  = d;
      inp_if.tkeep  = (w == nwords - 1) ? last_keep : 16'hFFFF;
      inp_if.tlast  = (w == nwords - 1);
      inp_if.tuser  = tuser;
      inp_if.tvalid = 1'b1;
      waited = 0;
      do begin
        @(posedge clk);
        #1;
        waited++;
      end while (!acc && waited < 100);
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: beat %0d not accepted after %0d cycles, required acceptance", w, waited);
        return;
      end
      stalls += waited - 1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sbq.size() != 0 || fcr_idle !== 1'b1) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_queue_empty"}, 128'(sbq.size()), 128'(0));
    check({name, "_idle"}, 128'(fcr_idle), 128'(1));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tvalid"}, 128'(outp_if.tvalid), 128'(0));
    check({name, "_tlast"}, 128'(outp_if.tlast), 128'(0));
    check({name, "_tkeep"}, 128'(outp_if.tkeep), 128'(0));
    check({name, "_tdata"}, outp_if.tdata, 128'(0));
    check({name, "_tuser"}, outp_if.tuser, 128'(0));
    check({name, "_idle"}, 128'(fcr_idle), 128'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int sum_words;
    int w0;
    checks = 0; errors = 0; out_words = 0;
    bp_mode = 1'b0; bp_pat = 6'b001101; bp_cyc = 0; hold_pend = 1'b0;
    inp_if.tvalid = 1'b0; inp_if.tlast = 1'b0; inp_if.tdata = '0; inp_if.tkeep = '0; inp_if.tuser = '0;
    outp_if.tready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    outp_if.tready = 1'b1;
    @(posedge clk);
    #1;

    //            ethtype   ver    proto  dport     type  src_if    nw  last_keep  words stalls
    rows[0]  = '{16'h0800, 8'h05, 8'h11, WG_PORT,  8'd4, 5'b00001, 11, 16'h03FF, 0, 0};
    rows[1]  = '{16'h0800, 8'h45, 8'h11, WG_PORT,  8'd4, 5'b00010, 11, 16'h03FF, 8, 0};
    rows[2]  = '{16'h0800, 8'h45, 8'h11, WG_PORT,  8'd1, 5'b00100, 11, 16'h03FF, 8, 0};
    rows[3]  = '{16'h0800, 8'h45, 8'h11, WG_PORT,  8'd4, 5'b00010,  5, 16'h03FF, 2, 0};
    rows[4]  = '{16'h0800, 8'h45, 8'h11, WG_PORT,  8'd2, 5'b01000,  5, 16'h3FFF, 3, 0};
    rows[5]  = '{16'h0800, 8'h45, 8'h11, 16'h1234, 8'd1, 5'b00001,  6, 16'hFFFF, 0, 1};
    rows[6]  = '{16'h0800, 8'h45, 8'h06, WG_PORT,  8'd1, 5'b00001,  6, 16'hFFFF, 0, 0};
    rows[7]  = '{16'h0800, 8'h45, 8'h11, WG_PORT,  8'd5, 5'b00001,  6, 16'hFFFF, 0, 0};
    rows[8]  = '{16'h86DD, 8'h45, 8'h11, WG_PORT,  8'd1, 5'b00001,  6, 16'hFFFF, 0, 0};
    rows[9]  = '{16'h0800, 8'h45, 8'h11, WG_PORT,  8'd3, 5'b10000,  3, 16'hFFFF, 1, 0};
    rows[10] = '{16'h0800, 8'h45, 8'h11, WG_PORT,  8'd1, 5'b00001,  2, 16'hFFFF, 0, 0};
    rows[11] = '{16'h0800, 8'h45, 8'h11, WG_PORT,  8'd1, 5'b00100,  7, 16'h0001, 4, 0};
    rows[12] = '{16'h0800, 8'h45, 8'h11, WG_PORT,  8'd3, 5'b00010,  4, 16'hFFFF, 2, 0};

    sum_words = 0;
    for (int r = 0; r < 13; r++) begin
      build_frame(rows[r].ethertype, rows[r].ver, rows[r].proto, rows[r].dport, rows[r].wtype,
                  rows[r].nwords, rows[r].last_keep, r * 7 + 3);
      model_push(rows[r].wtype, rows[r].src_if, rows[r].dport);
      send_frame(rows[r].nwords, rows[r].last_keep, rows[r].src_if, rows[r].nwords, stalls);
      check($sformatf("stalls_row%0d", r), 128'(stalls), 128'(rows[r].exp_stalls));
      sum_words += rows[r].exp_words;
    end
    inp_if.tvalid = 1'b0;
    wait_drain("table");
    check("table_words", 128'(out_words), 128'(sum_words));

    // Output stalls of 1 and 2 cycles mid-packet, then hold the final word.
    build_frame(16'h0800, 8'h45, 8'h11, WG_PORT, 8'd4, 11, 16'h03FF, 91);
    model_push(8'd4, 5'b01000, WG_PORT);
    bp_cyc = 0;
    bp_mode = 1'b1;
    send_frame(11, 16'h03FF, 5'b01000, 11, stalls);
    bp_mode = 1'b0;
    inp_if.tvalid = 1'b0;
    #1;
    outp_if.tready = 1'b0;
    @(negedge clk);
    check("final_pending_valid", 128'(outp_if.tvalid), 128'(1));
    check("final_pending_last", 128'(outp_if.tlast), 128'(1));
    check("idle_while_pending", 128'(fcr_idle), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    outp_if.tready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_final", 128'(fcr_idle), 128'(1));
    wait_drain("backpressure");
    check("backpressure_words", 128'(out_words), 128'(sum_words + 8));

    // Asynchronous reset in the middle of a passing frame.
    build_frame(16'h0800, 8'h45, 8'h11, WG_PORT, 8'd4, 11, 16'h03FF, 55);
    model_push(8'd4, 5'b00001, WG_PORT);
    send_frame(11, 16'h03FF, 5'b00001, 5, stalls);
    #2;
    rst = 1'b1;
    inp_if.tvalid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sbq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    w0 = out_words;
    build_frame(16'h0800, 8'h45, 8'h11, WG_PORT, 8'd4, 5, 16'h03FF, 17);
    model_push(8'd4, 5'b00010, WG_PORT);
    send_frame(5, 16'h03FF, 5'b00010, 5, stalls);
    inp_if.tvalid = 1'b0;
    wait_drain("after_reset");
    check("after_reset_words", 128'(out_words - w0), 128'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpe_wg_disasm.md
Name: dpe_wg_disasm

Overview:
- Ingress-side WireGuard disassembler in the DPE pipeline.
- Parses Ethernet/IPv4/UDP headers on a 128-bit AXI-Stream frame, drops non-WireGuard frames, and strips the 42-byte L2–L4 header.
- Emits the UDP payload (the WireGuard message), byte-aligned to lane 0, with a 128-bit metadata sideband on tuser.
- Sits between the per-port ingress merge and the WireGuard crypto/routing stages.

Parameters:
DATA_WIDTH, 128, tdata width; fixed, all offsets below assume 16-byte words
INP_USER_WIDTH, 5, input tuser width (one-hot source interface)
OUTP_USER_WIDTH, 128, output tuser width (metadata)
WG_PORT, 16'd51820, UDP destination port accepted

Ports:
clk  in  1  clock (dpe_if clk)
rst  in  1  reset, asynchronous, active-high (dpe_if rst)
inp.tvalid/tready/tlast  in/out/in  1 each  input AXI-Stream handshake (dpe_if inp)
inp.tdata  in  128  frame bytes; byte 0 in [7:0]
inp.tkeep  in  16  byte enables, contiguous from lane 0, partial only on tlast
inp.tuser  in  5  source interface one-hot, valid on every beat
outp.tvalid/tready/tlast  out/in/out  1 each  output handshake (dpe_if outp)
outp.tdata  out  128  WireGuard message bytes, byte 0 in [7:0]
outp.tkeep  out  16  byte enables
outp.tuser  out  128  metadata, constant over the packet
fcr_idle  out  1  high when no frame is in flight and the output register is empty

Behaviour:
- Reset: outp.tvalid=0, outp.tlast=0, outp.tkeep=0, outp.tdata=0, outp.tuser=0, fcr_idle=1, FSM in HDR0. Reset mid-frame discards the frame; the next input beat is treated as word 0.
- Network byte order: multi-byte fields are big-endian across byte lanes.
- Word 0: ethertype is bytes 12–13 and must be 0x0800; byte 14 must be 0x45.
- Word 1: IP protocol (byte 23) must be 0x11. Capture src IP (bytes 26–29) and dst IP bytes 30–31.
- Word 2: capture dst IP bytes 32–33, UDP src port (34–35) and dst port (36–37); dst port must equal WG_PORT. WG type (byte 42) must be 1..4.
- FSM states: HDR0, HDR1, HDR2, PASS, FLUSH, DROP.
  - HDR0→HDR1→HDR2: one transition per accepted beat.
  - Any failed check, or tlast before HDR2 completes, → DROP. No check failing → PASS.
  - DROP: inp.tready=1; consume beats until tlast, then return to HDR0. No output is produced.
- Header states: inp.tready=1. The HDR2 beat loads a residual register with bytes 10–15 of word 2.
- Realignment: output word k = {in[k+3] bytes 0–9, in[k+2] bytes 10–15}, i.e. residual (6 bytes) in lanes 0–5 and new bytes in lanes 6–15.
- PASS: on each accepted input beat with n valid bytes:
  - If not last: emit a full word; residual ← bytes 10–15.
  - If last and n≤10: emit final word with tkeep = (6+n) ones, tlast=1, → HDR0.
  - If last and n>10: emit a full word, residual ← bytes 10..n-1, → FLUSH.
  - If HDR2 beat is itself tlast: emit residual (6 bytes) as the final word, tlast=1.
- FLUSH: inp.tready=0; emit residual with tkeep = (n-10) ones, tlast=1, → HDR0.
- Output register: single stage.
  - In PASS, inp.tready = !outp.tvalid || outp.tready.
  - outp.tvalid holds with stable data/keep/last/user until outp.tready.
  - Latency: first payload word appears 1 cycle after the word-3 beat is accepted.
- outp.tuser fields:
  - [31:0] src IP
  - [63:32] dst IP
  - [79:64] UDP src port
  - [95:80] UDP dst port
  - [100:96] inp.tuser latched at word 0
  - [103:101] 0
  - [111:104] WG type
  - [127:112] 0
- Length: derived solely from tlast/tkeep. Bytes beyond the UDP length field (e.g. Ethernet pad) are forwarded, not trimmed.
- fcr_idle = (state==HDR0) && !outp.tvalid.

Test Plan:
- Frame of 11 words (last tkeep 16'h03FF), byte14=0x05, tuser=5'b00001 → dropped; 11 beats accepted with tready=1; no outp.tvalid.
- Same frame with byte14=0x45, dst port 0xCA6C, WG type 4, tuser=5'b00010 → exactly 8 output words, all tkeep 16'hFFFF, tlast on 8th. Word 0 bytes 0–3 = 04 00 00 00. tuser[111:104]=4, tuser[100:96]=5'b00010, src/dst IP 10.9.0.1/10.9.0.2, ports 0xA9C6/0xCA6C.
- Type-1 frame back-to-back after the above, tuser=5'b00100 → 8 words, tuser[111:104]=1; no bubble between packets when outp.tready=1.
- 5-word keepalive (last tkeep 16'h03FF, UDP length 40) → 2 words, 32 bytes, second tkeep 16'hFFFF tlast=1.
- Last beat tkeep 16'h3FFF (14 bytes) → extra FLUSH word with tkeep 16'h000F, inp.tready=0 that cycle.
- outp.tready low for 1 and 2 cycles mid-packet → no data loss or duplication, outputs held stable; fcr_idle=1 only after final word handshakes; async rst mid-packet → all outputs 0, fcr_idle=1.
